// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use stalls, taken-branch flushes and multi-cycle FP op stalls.
// Optional HAZ_PERF_CNT_EN macro adds saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int MC_LAT = 8,
  parameter int CNT_W  = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic [4:0] id_rs3_addr_i,
  input  logic [2:0] id_use_i,
  input  logic [2:0] id_fp_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_rd_wren_I_i,
  input  logic       ex_rd_wren_F_i,
  input  logic       ex_is_load_i,
  input  logic       ex_br_taken_i,
  input  logic       ex_mc_start_i,
  output logic       pc_en_o,
  output logic [1:0] if_id_sel_o,
  output logic [1:0] id_ex_sel_o,
  output logic [1:0] ex_mem_sel_o,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic       busy_o
);

  typedef enum logic [1:0] {RUN, MC_BUSY, MC_DONE} state_t;

  localparam logic [1:0] SEL_LOAD  = 2'b00;
  localparam logic [1:0] SEL_HOLD  = 2'b01;
  localparam logic [1:0] SEL_CLEAR = 2'b11;

  // RUN covers the first stall cycle and MC_DONE the last, so the counter spans MC_LAT-2 busy cycles.
  localparam int               CNT_INIT_I = (MC_LAT > 2) ? MC_LAT - 3 : 0;
  localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(CNT_INIT_I);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0][4:0]  src_addr;
  logic [2:0]       src_hit;
  logic             lu;

  assign src_addr = {id_rs3_addr_i, id_rs2_addr_i, id_rs1_addr_i};

  // x0 is hardwired zero and never hazards; f0 is a real FP register.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      src_hit[i] = id_use_i[i] && (src_addr[i] == ex_rd_addr_i) &&
                   (id_fp_i[i] ? ex_rd_wren_F_i
                               : (ex_rd_wren_I_i && (src_addr[i] != 5'd0)));
    end
    lu = ex_is_load_i && (|src_hit);
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en_o      = 1'b1;
    if_id_sel_o  = SEL_LOAD;
    id_ex_sel_o  = SEL_LOAD;
    ex_mem_sel_o = SEL_LOAD;
    busy_o       = 1'b0;
    if (i_rst_n) begin
      unique case (state_q)
        RUN: begin
          if (ex_br_taken_i) begin
            if_id_sel_o = SEL_CLEAR;
            id_ex_sel_o = SEL_CLEAR;
          end else if (ex_mc_start_i) begin
            pc_en_o      = 1'b0;
            if_id_sel_o  = SEL_HOLD;
            id_ex_sel_o  = SEL_HOLD;
            ex_mem_sel_o = SEL_CLEAR;
            if (MC_LAT == 2) begin
              state_d = MC_DONE;
            end else begin
              state_d = MC_BUSY;
              cnt_d   = CNT_INIT;
            end
          end else if (lu) begin
            pc_en_o     = 1'b0;
            if_id_sel_o = SEL_HOLD;
            id_ex_sel_o = SEL_CLEAR;
          end
        end
        MC_BUSY: begin
          pc_en_o      = 1'b0;
          if_id_sel_o  = SEL_HOLD;
          id_ex_sel_o  = SEL_HOLD;
          ex_mem_sel_o = SEL_CLEAR;
          busy_o       = 1'b1;
          if (cnt_q == '0) state_d = MC_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        MC_DONE: begin
          // The multi-cycle op leaves EX on this edge, so its start flag is stale here.
          state_d = RUN;
          if (ex_br_taken_i) begin
            if_id_sel_o = SEL_CLEAR;
            id_ex_sel_o = SEL_CLEAR;
          end else if (lu) begin
            pc_en_o     = 1'b0;
            if_id_sel_o = SEL_HOLD;
            id_ex_sel_o = SEL_CLEAR;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic flush_w;

  // Only the branch flush clears IF/ID, so that select identifies a flush cycle.
  assign flush_w = (if_id_sel_o == SEL_CLEAR);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_en_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_w && (flush_cnt_o != '1))  flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule
